// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//
// Parametrised register file for the ID stage with a same-cycle
// write-to-read bypass and a per-register pending-write scoreboard.
// Long-latency writers mark their destination at issue (iss_*) and clear
// the mark when their writeback retires (wr_retire_i). Readers of a
// register with unretired writes see rd_busy_o, and stall_o is asserted
// when any requesting port is busy.
//
// Optional feature: define SCOREBOARD_STATS_EN to build a saturating
// 32-bit stall-cycle counter on stall_cnt_o. If it is not defined,
// stall_cnt_o is tied to 0.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-low reset
//   rd_req_i     per-port read request (NRD)
//   rd_addr_i    read addresses, port p at [p*AW +: AW]
//   rd_data_o    read data, port p at [p*XLEN +: XLEN] (combinational)
//   rd_busy_o    per-port: addressed register has an unretired write
//   stall_o      OR over ports of (rd_req_i & rd_busy_o)
//   wr_en_i      writeback valid
//   wr_addr_i    writeback register
//   wr_data_i    writeback data
//   wr_retire_i  writeback retires one pending issue of wr_addr_i
//   iss_en_i     issue: one more pending write to iss_addr_i
//   iss_addr_i   issued destination register
//   iss_ready_o  iss_addr_i counter is not saturated
//   err_o        sticky protocol error (issue to full / retire of empty)
//   stall_cnt_o  stall-cycle counter (0 unless SCOREBOARD_STATS_EN)
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int PEND_W = 2,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NRD-1:0]      rd_req_i,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]      rd_busy_o,
    output logic                stall_o,
    input  logic                wr_en_i,
    input  logic [AW-1:0]       wr_addr_i,
    input  logic [XLEN-1:0]     wr_data_i,
    input  logic                wr_retire_i,
    input  logic                iss_en_i,
    input  logic [AW-1:0]       iss_addr_i,
    output logic                iss_ready_o,
    output logic                err_o,
    output logic [31:0]         stall_cnt_o
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [XLEN-1:0]   regs_q [NREG];
    logic [XLEN-1:0]   regs_d [NREG];
    logic [PEND_W-1:0] pend_q [NREG];
    logic [PEND_W-1:0] pend_d [NREG];
    logic              err_q;
    logic              err_d;

    logic retire_now;
    logic iss_sat;
    logic retire_empty;

    // A retirement is only meaningful alongside a valid writeback.
    assign retire_now   = wr_en_i & wr_retire_i;
    assign iss_sat      = iss_en_i && (iss_addr_i != '0) && (pend_q[iss_addr_i] == PEND_MAX);
    assign retire_empty = retire_now && (wr_addr_i != '0) && (pend_q[wr_addr_i] == '0);

    assign iss_ready_o  = (iss_addr_i == '0) || (pend_q[iss_addr_i] != PEND_MAX);
    assign err_o        = err_q;

    // -------------------------------------------------------------------------
    // Next-state: array write, pending counters, sticky error
    // -------------------------------------------------------------------------
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        err_d  = err_q | iss_sat | retire_empty;

        if (wr_en_i && (wr_addr_i != '0)) begin
            regs_d[wr_addr_i] = wr_data_i;
        end

        for (int r = 1; r < NREG; r++) begin
            logic inc;
            logic dec;
            inc = iss_en_i && (iss_addr_i == AW'(r)) && (pend_q[r] != PEND_MAX);
            dec = retire_now && (wr_addr_i == AW'(r)) && (pend_q[r] != '0);
            // Issue and retire to the same register cancel out.
            if (inc && !dec) begin
                pend_d[r] = pend_q[r] + PEND_ONE;
            end else if (dec && !inc) begin
                pend_d[r] = pend_q[r] - PEND_ONE;
            end
        end

        // Register 0 is hardwired: never stored, never pending.
        regs_d[0] = '0;
        pend_d[0] = '0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
                pend_q[r] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Read ports: bypass from the writeback bus, busy from the scoreboard
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0] a;
            assign a = rd_addr_i[gi*AW +: AW];

            assign rd_data_o[gi*XLEN +: XLEN] =
                (a == '0)                       ? '0        :
                (wr_en_i && (wr_addr_i == a))   ? wr_data_i :
                                                  regs_q[a];

            // count - retire_now != 0: a final retirement this cycle frees
            // the reader immediately, its data arriving through the bypass.
            assign rd_busy_o[gi] = (a != '0) && (pend_q[a] != '0) &&
                                   !(retire_now && (wr_addr_i == a) && (pend_q[a] == PEND_ONE));
        end
    endgenerate

    assign stall_o = |(rd_req_i & rd_busy_o);

    // -------------------------------------------------------------------------
    // Optional stall statistics
    // -------------------------------------------------------------------------
`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_regfile_scoreboard
//
// Table-driven bench for regfile_scoreboard (default parameters). Each
// record drives one cycle of inputs and holds the outputs expected in that
// cycle; expectations are queued when driven and popped when sampled.
// A short hand-written sequence at the end exercises the stall counter.
// -----------------------------------------------------------------------------
module tb_regfile_scoreboard;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic [NRD-1:0]      rd_req_i;
    logic [NRD*AW-1:0]   rd_addr_i;
    logic [NRD*XLEN-1:0] rd_data_o;
    logic [NRD-1:0]      rd_busy_o;
    logic                stall_o;
    logic                wr_en_i;
    logic [AW-1:0]       wr_addr_i;
    logic [XLEN-1:0]     wr_data_i;
    logic                wr_retire_i;
    logic                iss_en_i;
    logic [AW-1:0]       iss_addr_i;
    logic                iss_ready_o;
    logic                err_o;
    logic [31:0]         stall_cnt_o;

    regfile_scoreboard #(
        .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .PEND_W(2)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i),
        .rd_data_o(rd_data_o), .rd_busy_o(rd_busy_o), .stall_o(stall_o),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .wr_retire_i(wr_retire_i),
        .iss_en_i(iss_en_i), .iss_addr_i(iss_addr_i), .iss_ready_o(iss_ready_o),
        .err_o(err_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst_n;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ret;
        logic        ie;
        logic [4:0]  ia;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [1:0]  req;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  busy;
        logic        stall;
        logic        rdy;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  busy;
        logic        stall;
        logic        rdy;
        logic        err;
        logic [31:0] scnt;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int checks   = 0;
    int failures = 0;
    logic [31:0] scnt_model = 0;

    function automatic void v(logic rst_n, logic we, logic [4:0] wa, logic [31:0] wd,
                              logic ret, logic ie, logic [4:0] ia,
                              logic [4:0] ra0, logic [4:0] ra1, logic [1:0] req,
                              logic [31:0] d0, logic [31:0] d1, logic [1:0] busy,
                              logic stall, logic rdy, logic err);
        vec_t t;
        t.rst_n = rst_n; t.we = we; t.wa = wa; t.wd = wd; t.ret = ret;
        t.ie = ie; t.ia = ia; t.ra0 = ra0; t.ra1 = ra1; t.req = req;
        t.d0 = d0; t.d1 = d1; t.busy = busy; t.stall = stall; t.rdy = rdy; t.err = err;
        tbl.push_back(t);
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s vec=%0d actual=0x%08h required=0x%08h", name, idx, act, req);
        end
    endtask

    task automatic apply(int idx, vec_t t);
        exp_t e;
        exp_t g;
        @(negedge clk_i);
        rst_i       = t.rst_n;
        wr_en_i     = t.we;
        wr_addr_i   = t.wa;
        wr_data_i   = t.wd;
        wr_retire_i = t.ret;
        iss_en_i    = t.ie;
        iss_addr_i  = t.ia;
        rd_addr_i   = {t.ra1, t.ra0};
        rd_req_i    = t.req;
        e.d0 = t.d0; e.d1 = t.d1; e.busy = t.busy; e.stall = t.stall;
        e.rdy = t.rdy; e.err = t.err;
`ifdef SCOREBOARD_STATS_EN
        e.scnt = scnt_model;
`else
        e.scnt = 32'd0;
`endif
        sb.push_back(e);
        #2;
        g = sb.pop_front();
        chk("rd_data0", idx, rd_data_o[31:0], g.d0);
        chk("rd_data1", idx, rd_data_o[63:32], g.d1);
        chk("rd_busy", idx, {30'd0, rd_busy_o}, {30'd0, g.busy});
        chk("stall", idx, {31'd0, stall_o}, {31'd0, g.stall});
        chk("iss_ready", idx, {31'd0, iss_ready_o}, {31'd0, g.rdy});
        chk("err", idx, {31'd0, err_o}, {31'd0, g.err});
        chk("stall_cnt", idx, stall_cnt_o, g.scnt);
        $display("vec %0d rst_n=%0b we=%0b wa=%0d wd=%08h ret=%0b ie=%0b ia=%0d ra=%0d/%0d d=%08h/%08h busy=%02b stall=%0b rdy=%0b err=%0b scnt=%0d",
                 idx, t.rst_n, t.we, t.wa, t.wd, t.ret, t.ie, t.ia, t.ra0, t.ra1,
                 rd_data_o[31:0], rd_data_o[63:32], rd_busy_o, stall_o, iss_ready_o, err_o, stall_cnt_o);
        // Model of the stall counter across the coming edge.
        if (!t.rst_n)        scnt_model = 0;
        else if (t.stall)    scnt_model = scnt_model + 1;
    endtask

    initial begin
        //  rst we wa  wd            ret ie ia  ra0 ra1 req | d0            d1            busy stall rdy err
        v(1, 0, 0,  32'h0,        0, 0, 0,  5,  0,  0,   32'h0,        32'h0,        0,   0,    1,  0); // 0 reset state
        v(1, 1, 5,  32'hDEADBEEF, 0, 0, 0,  5,  5,  3,   32'hDEADBEEF, 32'hDEADBEEF, 0,   0,    1,  0); // 1 bypass
        v(1, 0, 0,  32'h0,        0, 0, 0,  5,  0,  3,   32'hDEADBEEF, 32'h0,        0,   0,    1,  0); // 2 stored, x0
        v(1, 0, 0,  32'h0,        0, 1, 7,  7,  0,  1,   32'h0,        32'h0,        0,   0,    1,  0); // 3 issue x7
        v(1, 0, 0,  32'h0,        0, 0, 0,  7,  0,  1,   32'h0,        32'h0,        1,   1,    1,  0); // 4 busy
        v(1, 0, 0,  32'h0,        0, 0, 0,  7,  0,  1,   32'h0,        32'h0,        1,   1,    1,  0); // 5
        v(1, 0, 0,  32'h0,        0, 0, 0,  7,  0,  1,   32'h0,        32'h0,        1,   1,    1,  0); // 6
        v(1, 1, 7,  32'h11,       1, 0, 0,  7,  0,  1,   32'h11,       32'h0,        0,   0,    1,  0); // 7 final retire
        v(1, 0, 0,  32'h0,        0, 0, 0,  7,  0,  1,   32'h11,       32'h0,        0,   0,    1,  0); // 8
        v(1, 0, 0,  32'h0,        0, 1, 3,  3,  0,  1,   32'h0,        32'h0,        0,   0,    1,  0); // 9 issue x3 #1
        v(1, 0, 0,  32'h0,        0, 1, 3,  3,  0,  1,   32'h0,        32'h0,        1,   1,    1,  0); // 10 #2
        v(1, 0, 0,  32'h0,        0, 1, 3,  3,  0,  1,   32'h0,        32'h0,        1,   1,    1,  0); // 11 #3
        v(1, 0, 0,  32'h0,        0, 1, 3,  3,  0,  1,   32'h0,        32'h0,        1,   1,    0,  0); // 12 saturated
        v(1, 1, 3,  32'h33,       1, 0, 0,  3,  0,  1,   32'h33,       32'h0,        1,   1,    1,  1); // 13 retire 1
        v(1, 1, 3,  32'h34,       1, 0, 0,  3,  0,  1,   32'h34,       32'h0,        1,   1,    1,  1); // 14 retire 2
        v(1, 1, 3,  32'h35,       1, 0, 0,  3,  0,  1,   32'h35,       32'h0,        0,   0,    1,  1); // 15 retire 3
        v(1, 0, 0,  32'h0,        0, 0, 0,  3,  0,  1,   32'h35,       32'h0,        0,   0,    1,  1); // 16
        v(1, 0, 0,  32'h0,        0, 1, 9,  9,  0,  1,   32'h0,        32'h0,        0,   0,    1,  1); // 17 issue x9
        v(1, 1, 9,  32'h99,       1, 1, 9,  9,  0,  1,   32'h99,       32'h0,        0,   0,    1,  1); // 18 issue+retire
        v(1, 0, 0,  32'h0,        0, 0, 0,  9,  0,  1,   32'h99,       32'h0,        1,   1,    1,  1); // 19 still busy
        v(1, 1, 9,  32'h9A,       1, 0, 0,  9,  0,  1,   32'h9A,       32'h0,        0,   0,    1,  1); // 20
        v(0, 0, 0,  32'h0,        0, 0, 0,  9,  0,  1,   32'h9A,       32'h0,        0,   0,    1,  1); // 21 reset
        v(1, 1, 4,  32'h22,       1, 0, 0,  4,  4,  3,   32'h22,       32'h22,       0,   0,    1,  0); // 22 retire empty
        v(1, 0, 0,  32'h0,        0, 0, 0,  4,  9,  3,   32'h22,       32'h0,        0,   0,    1,  1); // 23 err set
        v(1, 0, 0,  32'h0,        0, 1, 4,  4,  0,  1,   32'h22,       32'h0,        0,   0,    1,  1); // 24 issue x4
        v(0, 0, 0,  32'h0,        0, 0, 0,  4,  0,  1,   32'h22,       32'h0,        1,   1,    1,  1); // 25 reset pending
        v(1, 0, 0,  32'h0,        0, 0, 0,  4,  4,  3,   32'h0,        32'h0,        0,   0,    1,  0); // 26 cleared
        v(1, 1, 0,  32'hFFFF,     1, 1, 0,  0,  0,  3,   32'h0,        32'h0,        0,   0,    1,  0); // 27 x0 ignored
        v(1, 0, 0,  32'h0,        0, 0, 0,  0,  0,  3,   32'h0,        32'h0,        0,   0,    1,  0); // 28
        // Stall-counter sequence: issue x7 then five stalled cycles.
        v(1, 0, 0,  32'h0,        0, 1, 7,  7,  0,  1,   32'h0,        32'h0,        0,   0,    1,  0); // 29
        for (int k = 0; k < 5; k++)
            v(1, 0, 0, 32'h0,     0, 0, 0,  7,  0,  1,   32'h0,        32'h0,        1,   1,    1,  0); // 30..34
        v(1, 0, 0,  32'h0,        0, 0, 0,  0,  0,  0,   32'h0,        32'h0,        0,   0,    1,  0); // 35

        rst_i = 1'b0; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
        wr_retire_i = 1'b0; iss_en_i = 1'b0; iss_addr_i = '0;
        rd_addr_i = '0; rd_req_i = '0;
        repeat (2) @(posedge clk_i);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(i, tbl[i]);
        end

        // Explicit counter check after exactly five stalled edges.
`ifdef SCOREBOARD_STATS_EN
        chk("stall_cnt_five", 35, stall_cnt_o, 32'd5);
`else
        chk("stall_cnt_tied", 35, stall_cnt_o, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the fixed 32x32, 2-read/1-write register file used by the 5-stage pipeline.
- Adds configurable width, depth and read-port count, plus same-cycle write-to-read bypass.
- Adds a per-register pending-write scoreboard so long-latency writers (e.g. loads from a multi-cycle data memory) can be issued ahead of writeback.
- Sits in ID: read addresses come from IF/ID; write and retire come from MEM/WB; stall_o feeds PC/IF_ID write-enables.

Parameters:
- XLEN, 32: register data width.
- NREG, 32: number of architectural registers (power of 2, >=2); AW = clog2(NREG).
- NRD, 2: number of read ports (1..4).
- PEND_W, 2: width of each pending counter; maximum outstanding writes per register = 2^PEND_W - 1.

Ports:
- clk_i in 1: clock, rising edge.
- rst_i in 1: reset, synchronous, active-low.
- rd_req_i in NRD: read port p is in use this cycle.
- rd_addr_i in NRD*AW: read addresses, port p at [p*AW +: AW].
- rd_data_o out NRD*XLEN: read data, port p at [p*XLEN +: XLEN].
- rd_busy_o out NRD: port p's register has an unretired pending write.
- stall_o out 1: OR over p of (rd_req_i[p] & rd_busy_o[p]).
- wr_en_i in 1: writeback valid.
- wr_addr_i in AW: writeback register.
- wr_data_i in XLEN: writeback data.
- wr_retire_i in 1: this writeback retires one pending issue for wr_addr_i.
- iss_en_i in 1: mark iss_addr_i as having one more pending write.
- iss_addr_i in AW: destination being issued.
- iss_ready_o out 1: iss_addr_i counter not saturated (always 1 for register 0).
- err_o out 1: sticky protocol-error flag.
- stall_cnt_o out 32: stall-cycle counter (see Optional Feature).

Behaviour:
- Reset (rst_i==0 at a rising edge):
  - all registers cleared to 0, all pending counters to 0, err_o to 0, stall counter to 0.
  - Outputs follow combinationally from the cleared state.
  - A reset during outstanding issues drops them all; no error is raised.
- Register 0: reads always 0, never busy; writes, issues and retires to it are ignored and raise no error.
- Reads are combinational. Per port p, with a = rd_addr_i[p]:
  - a==0 -> 0.
  - else if wr_en_i and wr_addr_i==a -> wr_data_i (same-cycle bypass).
  - else -> stored value.
- Writes: when wr_en_i and wr_addr_i!=0, the array updates at the rising edge; the value is visible via the array from the next cycle.
- Counter update for register r, per edge:
  - +1 if iss_en_i & iss_addr_i==r & counter not saturated.
  - -1 if wr_en_i & wr_retire_i & wr_addr_i==r & counter!=0.
  - Both conditions true -> counter unchanged.
- Busy: rd_busy_o[p] = (count[a] - retire_now[a]) != 0, where retire_now[a] is 1 when a retiring write to a occurs this cycle and count[a]!=0. A final retirement therefore unblocks the reader in the same cycle, with its data supplied by the bypass.
- Issue is not gated by busy, so WAW issue is allowed.
- Issue to a saturated counter:
  - ignored, counter unchanged;
  - iss_ready_o==0 in that cycle;
  - err_o set.
- Retire (wr_en_i & wr_retire_i) to a register whose counter is 0:
  - the write still occurs;
  - counter stays 0;
  - err_o set.
- err_o clears only on reset.
- wr_retire_i is ignored when wr_en_i==0.
- No internal latency beyond a single register stage; stall_o is purely combinational from inputs and state.

Optional Feature:
- Macro: SCOREBOARD_STATS_EN.
- Defined: a 32-bit counter increments at each edge where stall_o==1 and rst_i==1. It saturates at 0xFFFFFFFF and stall_cnt_o shows the counter value.
- Not defined: no counter logic is generated and stall_cnt_o is tied to 0.

Test Plan:
- Reset, then write x5=0xDEADBEEF and read both ports at x5 the same cycle -> rd_data_o=0xDEADBEEF via bypass; next cycle, with no write, still 0xDEADBEEF; x0 read -> 0.
- Issue x7, then read x7 with rd_req=1 over 3 cycles -> rd_busy_o[0]=1, stall_o=1. Retiring write x7=0x11 -> busy=0, stall=0, data=0x11 that cycle.
- PEND_W=2: issue x3 three times -> iss_ready_o=1 each time. Fourth issue -> iss_ready_o=0, err_o=1. Three retires -> busy falls only on the third retire.
- Issue x9 and retire x9 in the same cycle with count=1 -> count stays 1 and x9 remains busy the next cycle.
- Retire x4 with count 0 and data 0x22 -> x4 reads 0x22, err_o=1. Reset mid-pending (x4 issued) -> busy=0, err_o=0, x4=0.
- With SCOREBOARD_STATS_EN defined: 5 stalled cycles -> stall_cnt_o=5. Without the macro -> stall_cnt_o=0.
